// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA burst read master.
// Holds the controller state encoding and the burst sizing function.
package dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dma_state_e;

    // Smallest of the three limits on a burst: the configured maximum,
    // the words still to request and the words left before the next
    // MAX_BURST-aligned block boundary.
    function automatic logic [31:0] burst_size(input logic [31:0] maxBurst,
                                               input logic [31:0] remaining,
                                               input logic [31:0] toBoundary);
        logic [31:0] size;
        size = maxBurst;
        if (remaining < size) size = remaining;
        if (toBoundary < size) size = toBoundary;
        return size;
    endfunction

endpackage

// File: rtl/dma_rd_credit.sv
// Outstanding-word tracker for the burst read master.
// Counts words requested but not yet returned and decides whether the
// downstream FIFO has room for the next candidate burst.
module dma_rd_credit
    import dma_pkg::*;
#(
    parameter int LEN_W = 16,
    parameter int BC_W  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_en,
    input  logic             accept_i,
    input  logic [BC_W-1:0]  acceptCount_i,
    input  logic             dataValid_i,
    input  logic [LEN_W:0]   fifoFree_i,
    input  logic [BC_W-1:0]  reqCount_i,
    output logic             creditOk_o,
    output logic             idle_o
);

    localparam logic [LEN_W:0] ONE = (LEN_W+1)'(1);

    logic [LEN_W:0] outstanding_q;
    logic [LEN_W:0] outstanding_d;

    // Net effect of a burst acceptance and a returned word in the same cycle.
    always_comb begin
        outstanding_d = outstanding_q;
        if (accept_i) outstanding_d = outstanding_d + (LEN_W+1)'(acceptCount_i);
        if (dataValid_i) outstanding_d = outstanding_d - ONE;
    end

    // Outstanding counter; frozen while the global enable is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding_q <= '0;
        end else if (clk_en) begin
            outstanding_q <= outstanding_d;
        end
    end

    // Room is needed for everything already in flight plus the new burst.
    assign creditOk_o = ({1'b0, fifoFree_i} >= ({1'b0, outstanding_q} + (LEN_W+2)'(reqCount_i)));
    assign idle_o     = (outstanding_q == '0);

endmodule

// File: rtl/dma_burst_read_master.sv
// Burst read master: splits a word-count transfer into bursts that never
// cross a MAX_BURST-word aligned block, throttled by downstream FIFO space.
// Optional feature macro DMA_RD_PIPELINED_EN: when defined, new bursts may be
// issued while earlier ones are still returning data; otherwise only one
// burst is in flight at a time.
module dma_burst_read_master
    import dma_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 8,
    localparam int BC_W     = $clog2(MAX_BURST) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_en,
    input  logic              go,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  xfer_words,
    input  logic [LEN_W:0]    fifo_free,
    output logic [ADDR_W-1:0] read_address,
    output logic              read,
    output logic [BC_W-1:0]   burstcount,
    input  logic              read_waitrequest,
    input  logic              readdatavalid,
    input  logic [DATA_W-1:0] readdata,
    output logic              fifo_wr,
    output logic [DATA_W-1:0] fifo_wdata,
    output logic              done,
    output logic              busy
);

    localparam int BYTES   = DATA_W / 8;
    localparam int BYTE_SH = $clog2(BYTES);

    dma_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remain_q;
    logic              read_q;
    logic [ADDR_W-1:0] readAddr_q;
    logic [BC_W-1:0]   burstCnt_q;
    logic              done_q;
    logic              busy_q;

    logic [ADDR_W-1:0] addr_d;
    logic [LEN_W-1:0]  remain_d;
    logic [ADDR_W-1:0] wordAddr;
    logic [BC_W-1:0]   blkIdx;
    logic [BC_W-1:0]   toBoundary;
    logic [BC_W-1:0]   remainCap;
    logic [BC_W-1:0]   nextBurst;
    logic              accept;
    logic              fifoWr;
    logic              creditOk;
    logic              noneOutstanding;
    logic              issueOk;

    // Position within the aligned block decides how far the next burst may run.
    assign wordAddr   = addr_q >> BYTE_SH;
    assign blkIdx     = BC_W'(wordAddr & ADDR_W'(MAX_BURST - 1));
    assign toBoundary = BC_W'(MAX_BURST) - blkIdx;
    assign remainCap  = (remain_q >= LEN_W'(MAX_BURST)) ? BC_W'(MAX_BURST) : BC_W'(remain_q);
    assign nextBurst  = BC_W'(burst_size(32'(MAX_BURST), 32'(remainCap), 32'(toBoundary)));

    // Pointer and count after the current burst is accepted.
    assign addr_d   = addr_q + (ADDR_W'(burstCnt_q) << BYTE_SH);
    assign remain_d = remain_q - LEN_W'(burstCnt_q);

    assign accept = read_q & ~read_waitrequest & clk_en;
    assign fifoWr = readdatavalid & clk_en & busy_q;

    dma_rd_credit #(
        .LEN_W (LEN_W),
        .BC_W  (BC_W)
    ) u_credit (
        .clk           (clk),
        .reset_n       (reset_n),
        .clk_en        (clk_en),
        .accept_i      (accept),
        .acceptCount_i (burstCnt_q),
        .dataValid_i   (fifoWr),
        .fifoFree_i    (fifo_free),
        .reqCount_i    (nextBurst),
        .creditOk_o    (creditOk),
        .idle_o        (noneOutstanding)
    );

`ifdef DMA_RD_PIPELINED_EN
    assign issueOk = creditOk;
`else
    assign issueOk = creditOk & noneOutstanding;
`endif

    // Transfer controller: capture, issue bursts, wait for data, pulse done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            read_q     <= 1'b0;
            readAddr_q <= '0;
            burstCnt_q <= BC_W'(1);
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else if (clk_en) begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        addr_q   <= start_addr;
                        remain_q <= xfer_words;
                        busy_q   <= 1'b1;
                        state_q  <= (xfer_words == '0) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (read_q) begin
                        if (!read_waitrequest) begin
                            read_q   <= 1'b0;
                            addr_q   <= addr_d;
                            remain_q <= remain_d;
                            if (remain_d == '0) state_q <= ST_DRAIN;
                        end
                    end else if (issueOk) begin
                        read_q     <= 1'b1;
                        readAddr_q <= addr_q;
                        burstCnt_q <= nextBurst;
                    end
                end
                ST_DRAIN: begin
                    if (noneOutstanding) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign read_address = readAddr_q;
    assign read         = read_q;
    assign burstcount   = burstCnt_q;
    assign done         = done_q;
    assign busy         = busy_q;
    assign fifo_wr      = fifoWr;
    assign fifo_wdata   = readdata;

endmodule

// File: tb/tb_dma_burst_read_master.sv
// Directed bench for dma_burst_read_master with a simple burst slave that
// returns the word address as data, one word per cycle.
module tb_dma_burst_read_master;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int LEN_W     = 16;
    localparam int MAX_BURST = 8;
    localparam int BC_W      = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              clk_en = 1'b1;
    logic              go = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [LEN_W-1:0]  xfer_words = '0;
    logic [LEN_W:0]    fifo_free = 17'd64;
    logic [ADDR_W-1:0] read_address;
    logic              read;
    logic [BC_W-1:0]   burstcount;
    logic              read_waitrequest = 1'b0;
    logic              readdatavalid = 1'b0;
    logic [DATA_W-1:0] readdata = '0;
    logic              fifo_wr;
    logic [DATA_W-1:0] fifo_wdata;
    logic              done;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] burstAddr[$];
    int          burstLen[$];
    logic [31:0] slaveQ[$];
    logic [31:0] wrData[$];
    int          wrCount = 0;
    int          doneCount = 0;
    bit          slaveHold = 1'b0;

    dma_burst_read_master #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LEN_W     (LEN_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .clk_en           (clk_en),
        .go               (go),
        .start_addr       (start_addr),
        .xfer_words       (xfer_words),
        .fifo_free        (fifo_free),
        .read_address     (read_address),
        .read             (read),
        .burstcount       (burstcount),
        .read_waitrequest (read_waitrequest),
        .readdatavalid    (readdatavalid),
        .readdata         (readdata),
        .fifo_wr          (fifo_wr),
        .fifo_wdata       (fifo_wdata),
        .done             (done),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // Observe at the falling edge, then drive returned data just after the rising edge.
    always @(negedge clk) begin
        if (fifo_wr) begin
            wrCount++;
            wrData.push_back(fifo_wdata);
        end
        if (done) doneCount++;
        if (read && !read_waitrequest && clk_en && reset_n) begin
            burstAddr.push_back(read_address);
            burstLen.push_back(int'(burstcount));
            for (int k = 0; k < int'(burstcount); k++)
                slaveQ.push_back(read_address + 32'(4 * k));
        end
        @(posedge clk);
        #1;
        if (!slaveHold && slaveQ.size() > 0) begin
            readdatavalid = 1'b1;
            readdata      = slaveQ.pop_front();
        end else begin
            readdatavalid = 1'b0;
            readdata      = '0;
        end
    end

    // Hard stop in case something hangs outside the bounded loops.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clearLog;
        burstAddr.delete();
        burstLen.delete();
        slaveQ.delete();
        wrData.delete();
        wrCount   = 0;
        doneCount = 0;
    endtask

    task automatic startXfer(input logic [31:0] addr, input int words);
        start_addr = addr;
        xfer_words = LEN_W'(words);
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic waitDone(input int maxCycles);
        for (int i = 0; i < maxCycles && doneCount == 0; i++) tick();
        tick();
        tick();
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick();
        tick();
        checks++; if (read !== 1'b0) begin errors++; $display("[TB] FAIL reset_read got %b want 0", read); end
        checks++; if (burstcount !== 4'd1) begin errors++; $display("[TB] FAIL reset_burstcount got %0d want 1", burstcount); end
        checks++; if (read_address !== 32'h0) begin errors++; $display("[TB] FAIL reset_address got %h want 0", read_address); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        logic [31:0] expA[3] = '{32'h100, 32'h120, 32'h140};
        int          expL[3] = '{8, 8, 4};
        logic [31:0] gotA;
        int          gotL;
        int          dataBad;
        clearLog();
        fifo_free = 17'd64;
        startXfer(32'h100, 20);
        waitDone(400);
        checks++; if (burstAddr.size() != 3) begin errors++; $display("[TB] FAIL basic_bursts got %0d want 3", burstAddr.size()); end
        for (int i = 0; i < 3; i++) begin
            gotA = (i < burstAddr.size()) ? burstAddr[i] : 'x;
            gotL = (i < burstLen.size()) ? burstLen[i] : -1;
            checks++; if (gotA !== expA[i]) begin errors++; $display("[TB] FAIL basic_addr%0d got %h want %h", i, gotA, expA[i]); end
            checks++; if (gotL != expL[i]) begin errors++; $display("[TB] FAIL basic_len%0d got %0d want %0d", i, gotL, expL[i]); end
        end
        checks++; if (wrCount != 20) begin errors++; $display("[TB] FAIL basic_wrcount got %0d want 20", wrCount); end
        dataBad = 0;
        for (int i = 0; i < 20; i++) begin
            gotA = (i < wrData.size()) ? wrData[i] : 'x;
            if (gotA !== 32'h100 + 32'(4 * i)) dataBad++;
        end
        checks++; if (dataBad != 0) begin errors++; $display("[TB] FAIL basic_data got %0d bad words want 0", dataBad); end
        checks++; if (doneCount != 1) begin errors++; $display("[TB] FAIL basic_done got %0d pulses want 1", doneCount); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle busy got %b want 0", busy); end
    endtask

    task automatic test_boundary;
        logic [31:0] gotA;
        int          gotL;
        clearLog();
        startXfer(32'h118, 8);
        waitDone(200);
        checks++; if (burstAddr.size() != 2) begin errors++; $display("[TB] FAIL split_bursts got %0d want 2", burstAddr.size()); end
        gotA = (burstAddr.size() > 0) ? burstAddr[0] : 'x;
        gotL = (burstLen.size() > 0) ? burstLen[0] : -1;
        checks++; if (gotA !== 32'h118 || gotL != 2) begin errors++; $display("[TB] FAIL split_first got %h/%0d want 118/2", gotA, gotL); end
        gotA = (burstAddr.size() > 1) ? burstAddr[1] : 'x;
        gotL = (burstLen.size() > 1) ? burstLen[1] : -1;
        checks++; if (gotA !== 32'h120 || gotL != 6) begin errors++; $display("[TB] FAIL split_second got %h/%0d want 120/6", gotA, gotL); end
        checks++; if (wrCount != 8) begin errors++; $display("[TB] FAIL split_wrcount got %0d want 8", wrCount); end
        checks++; if (doneCount != 1) begin errors++; $display("[TB] FAIL split_done got %0d want 1", doneCount); end
    endtask

    task automatic test_wrap;
        logic [31:0] gotA;
        int          gotL;
        clearLog();
        startXfer(32'hFFFF_FFF0, 8);
        waitDone(200);
        gotA = (burstAddr.size() > 0) ? burstAddr[0] : 'x;
        gotL = (burstLen.size() > 0) ? burstLen[0] : -1;
        checks++; if (gotA !== 32'hFFFF_FFF0 || gotL != 4) begin errors++; $display("[TB] FAIL wrap_first got %h/%0d want fffffff0/4", gotA, gotL); end
        gotA = (burstAddr.size() > 1) ? burstAddr[1] : 'x;
        gotL = (burstLen.size() > 1) ? burstLen[1] : -1;
        checks++; if (gotA !== 32'h0 || gotL != 4) begin errors++; $display("[TB] FAIL wrap_second got %h/%0d want 0/4", gotA, gotL); end
        checks++; if (wrCount != 8) begin errors++; $display("[TB] FAIL wrap_wrcount got %0d want 8", wrCount); end
    endtask

    task automatic test_credit;
        int readHigh;
        clearLog();
        fifo_free = 17'd5;
        startXfer(32'h200, 8);
        readHigh = 0;
        for (int i = 0; i < 10; i++) begin
            if (read !== 1'b0) readHigh++;
            tick();
        end
        checks++; if (readHigh != 0) begin errors++; $display("[TB] FAIL credit_hold read high %0d cycles want 0", readHigh); end
        fifo_free = 17'd8;
        for (int i = 0; i < 10 && read !== 1'b1; i++) tick();
        checks++; if (read !== 1'b1) begin errors++; $display("[TB] FAIL credit_release read got %b want 1", read); end
        checks++; if (burstcount !== 4'd8 || read_address !== 32'h200) begin errors++; $display("[TB] FAIL credit_burst got %0d@%h want 8@200", burstcount, read_address); end
        waitDone(200);
        checks++; if (wrCount != 8 || doneCount != 1) begin errors++; $display("[TB] FAIL credit_finish got wr %0d done %0d want 8 1", wrCount, doneCount); end
        fifo_free = 17'd64;
    endtask

    task automatic test_stall;
        int stableBad;
        clearLog();
        read_waitrequest = 1'b1;
        startXfer(32'h300, 4);
        for (int i = 0; i < 10 && read !== 1'b1; i++) tick();
        stableBad = 0;
        for (int i = 0; i < 4; i++) begin
            if (read !== 1'b1 || read_address !== 32'h300 || burstcount !== 4'd4) stableBad++;
            if (i < 3) tick();
        end
        checks++; if (stableBad != 0) begin errors++; $display("[TB] FAIL stall_stable got %0d unstable cycles want 0", stableBad); end
        read_waitrequest = 1'b0;
        waitDone(100);
        checks++; if (burstAddr.size() != 1) begin errors++; $display("[TB] FAIL stall_accepts got %0d want 1", burstAddr.size()); end
        checks++; if (wrCount != 4) begin errors++; $display("[TB] FAIL stall_wrcount got %0d want 4", wrCount); end
    endtask

    task automatic test_zero;
        clearLog();
        startXfer(32'h500, 0);
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL zero_cycle1 got done %b busy %b want 0 1", done, busy); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL zero_done got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy got %b want 0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL zero_pulse got %b want 0", done); end
        tick();
        checks++; if (burstAddr.size() != 0) begin errors++; $display("[TB] FAIL zero_reads got %0d want 0", burstAddr.size()); end
    endtask

    task automatic test_reset_drain;
        clearLog();
        slaveHold = 1'b1;
        startXfer(32'h400, 4);
        for (int i = 0; i < 20 && burstAddr.size() == 0; i++) tick();
        tick();
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL drain_busy got %b want 1", busy); end
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || read !== 1'b0) begin errors++; $display("[TB] FAIL drain_reset got busy %b read %b want 0 0", busy, read); end
        tick();
        reset_n = 1'b1;
        wrCount   = 0;
        doneCount = 0;
        slaveHold = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        checks++; if (wrCount != 0) begin errors++; $display("[TB] FAIL drain_stale_wr got %0d want 0", wrCount); end
        checks++; if (doneCount != 0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL drain_idle got done %0d busy %b want 0 0", doneCount, busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_wrap();
        test_credit();
        test_stall();
        test_zero();
        test_reset_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
